uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by uart_tx and uart_rx.
//   * FSM state encoding (kept as plain localparam constants so existing
//     uart_rx code that compares against them keeps compiling unchanged)
//   * default oversampling ratio used by both directions
// -----------------------------------------------------------------------------
package uart_pkg;

  // Oversampling ticks per bit produced by the shared baud-rate generator.
  localparam int unsigned UART_N_TICKS = 16;

  // State register width and encoding.
  localparam int unsigned UART_ST_W = 3;

  localparam logic [UART_ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [UART_ST_W-1:0] ST_START  = 3'd1;
  localparam logic [UART_ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [UART_ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [UART_ST_W-1:0] ST_STOP   = 3'd4;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- oversampled UART transmitter.
//
// Frame: start(0) + N_DATA data bits (LSB first) + [parity] + M_STOP stop(1).
// Every bit lasts exactly N_TICKS cycles of i_tick; i_tick comes from the
// external baud-rate generator in top_level.
//
// Build option:
//   UART_TX_PARITY_EN  -- when defined, one parity bit is inserted between the
//                         data and stop bits (EVEN_ODD_PARITY: 1 even, 0 odd).
//                         When undefined, no parity logic exists at all.
//
// All outputs are registered.  o_tx_done pulses for one cycle on the first
// IDLE cycle after the stop bit(s); a request seen in that same cycle starts
// the next frame on the following edge.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned N_DATA          = 8,
  parameter int unsigned M_STOP          = 1,
  parameter int unsigned N_TICKS         = UART_N_TICKS,
  parameter int unsigned EVEN_ODD_PARITY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_tx_start,
  input  logic [N_DATA-1:0] i_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_tx_done
);

  // Tick counter spans the longest segment (the stop period); the bit
  // counter is allowed to reach N_DATA on the final data bit.
  localparam int unsigned TICK_W = $clog2(N_TICKS * M_STOP);
  localparam int unsigned BIT_W  = $clog2(N_DATA + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(N_TICKS - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(N_TICKS * M_STOP - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_DATA - 1);

  // Reject configurations the counters and frame format are not built for.
  if (M_STOP < 1 || M_STOP > 2 || EVEN_ODD_PARITY > 1 || N_TICKS < 2) begin : g_bad_cfg
    $error("uart_tx: unsupported parameter combination");
  end

  logic [UART_ST_W-1:0] state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [N_DATA-1:0]    shreg_q, shreg_d;
  logic                 tx_d;
  logic                 busy_d;
  logic                 done_d;

`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Request is taken regardless of i_tick; the byte (and its parity)
        // is frozen here for the whole frame.
        if (i_tx_start) begin
          state_d = ST_START;
          tick_d  = '0;
          bit_d   = '0;
          shreg_d = i_data;
`ifdef UART_TX_PARITY_EN
          par_d   = (EVEN_ODD_PARITY != 0) ? (^i_data) : ~(^i_data);
`endif
        end
      end

      ST_START: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        if (i_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level and busy flag are decoded from the next state so that the
  // registered outputs line up with the state register.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, data and registered outputs; reset aborts any frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      o_tx      <= tx_d;
      o_busy    <= busy_d;
      o_tx_done <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity bit computed once at frame acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- scoreboard bench for uart_tx.
// Two instances: u_tx0 (8 data, 1 stop, even parity) and u_tx1 (8 data,
// 2 stop, odd parity).  Only the selected instance is out of reset.  The
// stimulus pushes expected frames; a monitor decodes the selected line and
// compares bit-by-bit, including busy/done behaviour and frame length.
// Parity expectations follow UART_TX_PARITY_EN as given to the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned NT = 16;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1, tick, start0, start1;
  logic [7:0] data;
  logic       tx0, busy0, done0, tx1, busy1, done1;
  logic       sel;
  logic       cur_tx, cur_busy, cur_done, cur_rst;

  uart_tx #(.N_DATA(8), .M_STOP(1), .N_TICKS(NT), .EVEN_ODD_PARITY(1)) u_tx0 (
    .i_clk(clk), .i_rst_n(rst_n0), .i_tick(tick), .i_tx_start(start0),
    .i_data(data), .o_tx(tx0), .o_busy(busy0), .o_tx_done(done0));

  uart_tx #(.N_DATA(8), .M_STOP(2), .N_TICKS(NT), .EVEN_ODD_PARITY(0)) u_tx1 (
    .i_clk(clk), .i_rst_n(rst_n1), .i_tick(tick), .i_tx_start(start1),
    .i_data(data), .o_tx(tx1), .o_busy(busy1), .o_tx_done(done1));

  assign cur_tx   = sel ? tx1   : tx0;
  assign cur_busy = sel ? busy1 : busy0;
  assign cur_done = sel ? done1 : done0;
  assign cur_rst  = sel ? rst_n1 : rst_n0;

  typedef struct {
    logic [7:0]  data;
    bit          par_en;
    bit          odd;
    int unsigned stop;
    int unsigned period;
    bit          b2b;
    bit          abort;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned period = 1;
  int unsigned tcnt = 0;
  int unsigned mcyc = 0;
  int unsigned last_done_cyc = 0;
  bit          mon_active = 1'b0;
  bit          chk_done_low = 1'b0;

  // Tick generator: one tick every 'period' cycles.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % period;
      tick = (tcnt == 0);
    end
  end

  function automatic exp_t mk(input logic [7:0] d, input bit b2b, input bit abort);
    exp_t e;
    e.data   = d;
    e.par_en = PAR_EN;
    e.odd    = sel;
    e.stop   = sel ? 2 : 1;
    e.period = period;
    e.b2b    = b2b;
    e.abort  = abort;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  task automatic sample();
    @(negedge clk);
    mcyc++;
  endtask

  task automatic handle_abort(input exp_t f);
    int unsigned g;
    bit          bad;
    n_cmp++;
    if (!f.abort || cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort data=%h: got tx=%b busy=%b done=%b abort_expected=%0d, want tx=1 busy=0 done=0 abort_expected=1",
               f.data, cur_tx, cur_busy, cur_done, f.abort);
    end
    g = 0;
    while (cur_rst !== 1'b1 && g < 200) begin
      sample();
      g++;
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (cur_done !== 1'b0 || cur_tx !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL post_reset_quiet: got a done pulse or low line after reset release, want tx=1 done=0");
    end
  endtask

  task automatic check_frame(input exp_t f);
    logic        segv [12];
    int unsigned segl [12];
    int unsigned nseg, bc, at;
    logic        p, gtx, gbusy, gdone;
    bit          bad;
    bc      = NT * f.period;
    segv[0] = 1'b0;
    segl[0] = bc;
    for (int i = 0; i < 8; i++) begin
      segv[1+i] = f.data[i];
      segl[1+i] = bc;
    end
    nseg = 9;
    if (f.par_en) begin
      p = ^f.data;
      if (f.odd) p = ~p;
      segv[nseg] = p;
      segl[nseg] = bc;
      nseg++;
    end
    segv[nseg] = 1'b1;
    segl[nseg] = bc * f.stop;
    nseg++;

    if (f.b2b) begin
      n_cmp++;
      if (mcyc != last_done_cyc + 1) begin
        n_err++;
        $display("FAIL b2b_gap data=%h: got start at cycle %0d, want cycle %0d", f.data, mcyc, last_done_cyc + 1);
      end
    end

    for (int s = 0; s < int'(nseg); s++) begin
      bad = 1'b0; at = 0; gtx = 1'b0; gbusy = 1'b0; gdone = 1'b0;
      for (int k = 0; k < int'(segl[s]); k++) begin
        if (!(s == 0 && k == 0)) sample();
        if (cur_rst !== 1'b1) begin
          handle_abort(f);
          return;
        end
        if (!bad && (cur_tx !== segv[s] || cur_busy !== 1'b1 || cur_done !== 1'b0)) begin
          bad = 1'b1; at = k; gtx = cur_tx; gbusy = cur_busy; gdone = cur_done;
        end
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL seg%0d data=%h: got tx=%b busy=%b done=%b at cycle %0d of %0d, want tx=%b busy=1 done=0",
                 s, f.data, gtx, gbusy, gdone, at, segl[s], segv[s]);
      end
    end

    sample();
    if (cur_rst !== 1'b1) begin
      handle_abort(f);
      return;
    end
    n_cmp++;
    if (cur_done !== 1'b1 || cur_busy !== 1'b0 || cur_tx !== 1'b1 || f.abort) begin
      n_err++;
      $display("FAIL frame_end data=%h: got done=%b busy=%b tx=%b (abort_expected=%0d), want done=1 busy=0 tx=1 abort_expected=0",
               f.data, cur_done, cur_busy, cur_tx, f.abort);
    end
    last_done_cyc = mcyc;
    chk_done_low  = 1'b1;
  endtask

  initial begin
    exp_t        f;
    int unsigned g;
    forever begin
      sample();
      if (chk_done_low) begin
        chk_done_low = 1'b0;
        n_cmp++;
        if (cur_done !== 1'b0) begin
          n_err++;
          $display("FAIL done_width: got done=%b one cycle after pulse, want 0", cur_done);
        end
      end
      if (cur_rst === 1'b1 && cur_tx === 1'b0) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got start bit at cycle %0d, want no frame", mcyc);
          g = 0;
          while (cur_busy === 1'b1 && g < 5000) begin
            sample();
            g++;
          end
        end else begin
          f = exp_q.pop_front();
          check_frame(f);
        end
        mon_active = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic send(input logic [7:0] d, input bit b2b, input bit abort, input bit push);
    int unsigned guard;
    guard = 0;
    @(posedge clk); #2;
    while (!tick && guard < 16) begin
      @(posedge clk); #2;
      guard++;
    end
    data = d;
    if (push) exp_q.push_back(mk(d, b2b, abort));
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk); #2;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned g, quiet;
    g = 0; quiet = 0;
    while (quiet < 20 && g < 20000) begin
      @(posedge clk); #2;
      g++;
      if (exp_q.size() == 0 && !mon_active && cur_busy === 1'b0) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 20) begin
      n_err++;
      $display("FAIL idle_timeout: got %0d pending frames after %0d cycles, want line idle", exp_q.size(), g);
    end
  endtask

  initial begin
    int unsigned g;
    sel = 1'b0; rst_n0 = 1'b0; rst_n1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; data = 8'h00;

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state_u0: got tx=%b busy=%b done=%b, want 1 0 0", tx0, busy0, done0);
    end
    n_cmp++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state_u1: got tx=%b busy=%b done=%b, want 1 0 0", tx1, busy1, done1);
    end
    rst_n0 = 1'b1;
    repeat (3) @(posedge clk);

    // 8N1, tick every cycle: 0,1,1,0,0,0,0,0,0,1
    period = 1;
    send(8'h03, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Tick every 4th cycle: 64-cycle bits.
    period = 4;
    send(8'h0C, 1'b0, 1'b0, 1'b1);
    wait_idle();
    period = 1;

    // Even parity instance: 8'h20 -> parity 1 when enabled.
    send(8'h20, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Mid-frame request with another byte must be ignored.
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (50) @(posedge clk);
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Reset in the middle of DATA, then a clean frame.
    send(8'h96, 1'b0, 1'b1, 1'b1);
    repeat (56) @(posedge clk);
    #2;
    rst_n0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n0 = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Two stop bits, odd parity, request held through the done pulse.
    rst_n0 = 1'b0;
    sel    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n1 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    data = 8'h20;
    exp_q.push_back(mk(8'h20, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hC3, 1'b1, 1'b0));
    start1 = 1'b1;
    @(posedge clk); #2;
    data = 8'hC3;
    g = 0;
    while (done1 !== 1'b1 && g < 2000) begin
      @(posedge clk); #2;
      g++;
    end
    n_cmp++;
    if (done1 !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout_u1: got no done pulse in %0d cycles, want one", g);
    end
    @(posedge clk); #2;
    start1 = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_tx
